muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit, downstream of RegisterFile.
- Consumes regData1/regData2 as operands.
- Returns a 32-bit result plus destination index to the writeback path, which drives RegisterFile we/reg3/dataIn.
- Fixed-latency, one operation in flight. The core stalls on busy.

---
 rtl/riscv_pkg.sv | 34 +++
 rtl/muldiv_unit.sv | 171 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32M multiply/divide definitions: funct3 op encodings,
// unit state encoding, iteration count and operand signedness helpers.
package riscv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    localparam int MULDIV_ITER = 32;

    // rs1 is treated as two's complement for MULH, MULHSU, DIV and REM.
    function automatic logic op_a_signed(input muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is treated as two's complement for MULH, DIV and REM.
    function automatic logic op_b_signed(input muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. One operation in flight, fixed
// 33-edge latency from the start edge to the done pulse for every op.
// Handshake: start is sampled on a rising edge only while busy=0 (IDLE or
// DONE); done/wb_we pulse for exactly one cycle with result/rd_out valid,
// and result holds until the next done or reset.
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd_in,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    output logic            busy,
    output logic            done,
    output logic            wb_we,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output muldiv_state_t   state_dbg
);

    localparam logic [5:0]      LAST_CNT = 6'(MULDIV_ITER);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};

    muldiv_state_t   state;
    logic [5:0]      cnt;
    muldiv_op_t      op;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN-1:0] opa_raw;
    // hi: multiply accumulator / partial remainder
    // lo: multiplier being consumed / dividend shifting into quotient
    logic [XLEN-1:0] hi, lo;

    assign state_dbg = state;

    // Request decode: magnitudes and sign flags of the incoming operands
    muldiv_op_t      req_op;
    logic            req_a_neg, req_b_neg;
    logic [XLEN-1:0] req_a_mag, req_b_mag;

    assign req_op    = muldiv_op_t'(funct3);
    assign req_a_neg = op_a_signed(req_op) && opA[XLEN-1];
    assign req_b_neg = op_b_signed(req_op) && opB[XLEN-1];
    assign req_a_mag = req_a_neg ? -opA : opA;
    assign req_b_mag = req_b_neg ? -opB : opB;

    // One shift-add multiply step and one restoring divide step
    logic            is_div;
    logic [XLEN:0]   mul_sum;
    logic [2*XLEN:0] mul_shift;
    logic [XLEN:0]   div_shifted;
    logic [XLEN+1:0] div_diff;

    assign is_div      = op[2];
    assign mul_sum     = {1'b0, hi} + (lo[0] ? {1'b0, a_mag} : '0);
    assign mul_shift   = {mul_sum, lo} >> 1;
    assign div_shifted = {hi, lo[XLEN-1]};
    assign div_diff    = {1'b0, div_shifted} - {2'b00, b_mag};

    // Sign and special-case fixup applied once all iterations are done
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_result;
    logic              res_neg, div_by_zero, sgn_ovf;

    assign res_neg     = a_neg ^ b_neg;
    assign prod        = {hi, lo};
    assign prod_fix    = res_neg ? -prod : prod;
    assign quot_fix    = res_neg ? -lo : lo;
    assign rem_fix     = a_neg ? -hi : hi;
    assign div_by_zero = (b_mag == '0);
    assign sgn_ovf     = ((op == OP_DIV) || (op == OP_REM)) && a_neg && (a_mag == MIN_NEG)
                         && b_neg && (b_mag == ONE);

    // Select the architectural result for the latched op
    always_comb begin
        fix_result = '0;
        case (op)
            OP_MUL:                       fix_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU: begin
                if (div_by_zero)  fix_result = '1;
                else if (sgn_ovf) fix_result = MIN_NEG;
                else              fix_result = quot_fix;
            end
            OP_REM, OP_REMU: begin
                if (div_by_zero)  fix_result = opa_raw;
                else if (sgn_ovf) fix_result = '0;
                else              fix_result = rem_fix;
            end
            default:              fix_result = '0;
        endcase
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            op      <= OP_MUL;
            a_neg   <= 1'b0;
            b_neg   <= 1'b0;
            a_mag   <= '0;
            b_mag   <= '0;
            opa_raw <= '0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wb_we   <= 1'b0;
            result  <= '0;
            rd_out  <= '0;
        end else begin
            done  <= 1'b0;
            wb_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op      <= req_op;
                        rd_out  <= rd_in;
                        a_neg   <= req_a_neg;
                        b_neg   <= req_b_neg;
                        a_mag   <= req_a_mag;
                        b_mag   <= req_b_mag;
                        opa_raw <= opA;
                        hi      <= '0;
                        lo      <= funct3[2] ? req_a_mag : req_b_mag;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (cnt == LAST_CNT) begin
                        result <= fix_result;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        wb_we  <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 6'd1;
                        if (is_div) begin
                            if (!div_diff[XLEN+1]) begin
                                hi <= div_diff[XLEN-1:0];
                                lo <= {lo[XLEN-2:0], 1'b1};
                            end else begin
                                hi <= div_shifted[XLEN-1:0];
                                lo <= {lo[XLEN-2:0], 1'b0};
                            end
                        end else begin
                            hi <= mul_shift[2*XLEN-1:XLEN];
                            lo <= mul_shift[XLEN-1:0];
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M cases, handshake corners, mid-op
// reset, and randomized ops against an arithmetic reference model.
module tb_muldiv_unit;
    import riscv_pkg::*;

    logic          clk;
    logic          rst;
    logic          start;
    logic [2:0]    funct3;
    logic [4:0]    rd_in;
    logic [31:0]   opA, opB;
    logic          busy, done, wb_we;
    logic [31:0]   result;
    logic [4:0]    rd_out;
    muldiv_state_t state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    logic [4:0]  exp_rd_q[$];

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct3    (funct3),
        .rd_in     (rd_in),
        .opA       (opA),
        .opB       (opB),
        .busy      (busy),
        .done      (done),
        .wb_we     (wb_we),
        .result    (result),
        .rd_out    (rd_out),
        .state_dbg (state_dbg)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: RV32M results from plain 64-bit arithmetic
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        q  = 0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = sa / sb;
                return q[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                q = sa % sb;
                return q[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Driver: present a request for the next edge (E0), then scramble operands
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp);
        funct3 = f;
        opA    = a;
        opB    = b;
        rd_in  = rd;
        start  = 1'b1;
        exp_q.push_back(exp);
        exp_rd_q.push_back(rd);
        @(posedge clk);
        #1;
        start  = 1'b0;
        opA    = $urandom;
        opB    = $urandom;
        rd_in  = 5'($urandom);
        funct3 = 3'($urandom);
    endtask

    // Wait for done (bounded), checking latency from E0 and the writeback
    task automatic wait_done(input int elapsed);
        int          k;
        logic [31:0] e;
        logic [4:0]  er;
        k = elapsed;
        while (k < 40 && done !== 1'b1) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 32) check_val("busy_run", 32'(busy), 32'd1);
        end
        check_val("latency", 32'(k), 32'd33);
        e  = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        er = (exp_rd_q.size() > 0) ? exp_rd_q.pop_front() : 5'd0;
        if (done === 1'b1) begin
            check_val("result", result, e);
            check_val("rd_out", 32'(rd_out), 32'(er));
            check_val("wb_we", 32'(wb_we), 32'd1);
            check_val("busy_done", 32'(busy), 32'd0);
        end
    endtask

    logic [2:0]  d_f[11] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] d_a[11] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                             32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                             32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b[11] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_e[11] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                             32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5,
                             32'h8000_0000, 32'd0};

    initial begin
        logic        saw_done;
        logic [2:0]  f;
        logic [31:0] a, b;
        int          gap;

        rst = 1'b1; start = 1'b0; funct3 = '0; rd_in = '0; opA = '0; opB = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_wb_we", 32'(wb_we), 32'd0);
        check_val("rst_result", result, 32'd0);
        check_val("rst_rd_out", 32'(rd_out), 32'd0);
        check_val("rst_state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // MUL 7 x -3, then done must be a single-cycle pulse
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
        check_val("busy_e1", 32'(busy), 32'd1);
        wait_done(0);
        @(posedge clk);
        #1;
        check_val("done_pulse", 32'(done), 32'd0);
        check_val("result_hold", result, 32'hFFFF_FFEB);

        // Directed high products, division and special cases
        for (int i = 0; i < 11; i++) begin
            issue(d_f[i], d_a[i], d_b[i], 5'(i + 1), d_e[i]);
            wait_done(0);
            @(posedge clk);
            #1;
        end

        // start pulsed at E5 while busy is ignored
        issue(3'd5, 32'd100, 32'd7, 5'd3, 32'd14);
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; funct3 = 3'd0; opA = 32'd1; opB = 32'd1; rd_in = 5'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(5);

        // Back-to-back: start held in the DONE cycle is accepted
        @(posedge clk);
        #1;
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE);
        wait_done(0);
        issue(3'd0, 32'd3, 32'd4, 5'd7, 32'd12);
        wait_done(0);
        @(posedge clk);
        #1;

        // Reset at E10 of a DIVU aborts it without a done pulse
        issue(3'd5, 32'd1000, 32'd3, 5'd8, 32'd333);
        void'(exp_q.pop_back());
        void'(exp_rd_q.pop_back());
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_done", 32'(done), 32'd0);
        check_val("abort_result", result, 32'd0);
        saw_done = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        check_val("abort_no_done", 32'(saw_done), 32'd0);
        issue(3'd7, 32'd10, 32'd3, 5'd2, 32'd1);
        wait_done(0);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            issue(f, a, b, 5'($urandom), model(f, a, b));
            wait_done(0);
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
